servo_ramp: RTL and testbench
=============================

SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter CLK_F, default 50, clock cycles per microsecond.
REQ-002 Parameter FRAME_US, default 20000, servo frame length in microseconds.
REQ-003 Parameter MIN_US, default 500, pulse width in microseconds for 0 degrees.
REQ-004 Parameter MAX_US, default 2500, pulse width in microseconds for 180 degrees.
REQ-005 Parameter CENTER_US, default 1500, pulse width in microseconds after reset.
REQ-006 Parameter STEP_US, default 10, maximum pulse-width change per frame in microseconds; must be at least 1.
REQ-007 CLK  input  1  the only clock; all logic on rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 cmd_valid  input  1  angle command present.
REQ-010 cmd_ready  output  1  block can accept a command.
REQ-011 cmd_angle  input  8  target angle in degrees, 0..180; values above 180 are treated as 180.
REQ-012 pul_len  output  16  registered pulse width in microseconds, feeds the downstream servo PWM generator.
REQ-013 busy  output  1  a command is being converted or ramped.
REQ-014 frame_tick  output  1  registered one-cycle pulse at each frame boundary.

Function
REQ-015 The frame timer SHALL have a prescaler counting 0..CLK_F-1 and a microsecond counter counting 0..FRAME_US-1; the microsecond counter increments when the prescaler wraps.
REQ-016 wrap SHALL be true when prescaler==CLK_F-1 and the microsecond counter is FRAME_US-1; on that edge both counters SHALL go to 0 and frame_tick SHALL go to 1 for exactly one cycle. The frame period is therefore CLK_F*FRAME_US cycles.
REQ-017 The frame timer SHALL run continuously, independent of FSM state.
REQ-018 The FSM states SHALL be IDLE, CONV and RAMP. cmd_ready SHALL equal (state==IDLE), and busy SHALL equal (state!=IDLE).
REQ-019 In IDLE, when cmd_valid and cmd_ready are both high, the block SHALL accept the command and move to CONV.
REQ-020 A command SHALL be accepted only on a valid&&ready edge. cmd_valid held high while busy SHALL be accepted on the first cycle back in IDLE.
REQ-021 On the command-accept edge, the target register SHALL load MIN_US + 11*a + floor(a/9), where a = min(cmd_angle, 180). This is exact floor(a*2000/180) for the default parameters: a=0 gives 500, a=90 gives 1500, a=180 gives 2500.
REQ-022 The target SHALL then be clamped to MIN_US..MAX_US, and all arithmetic SHALL be 16-bit unsigned.
REQ-023 In CONV (one cycle), if target==pul_len the FSM SHALL go to IDLE; otherwise it SHALL go to RAMP. No step is taken in CONV, even if wrap occurs.
REQ-024 In RAMP, on each wrap edge, with d = |target - pul_len|:
  - if d <= STEP_US: pul_len SHALL load target and the FSM SHALL go to IDLE on the same edge;
  - otherwise: pul_len SHALL move STEP_US toward target.
REQ-025 In RAMP, pul_len SHALL not change on non-wrap cycles.
REQ-026 pul_len SHALL only change on wrap edges, with no overshoot and no change of step direction within one ramp.
REQ-027 The last step of a ramp SHALL be the partial remainder (1..STEP_US).

Reset
REQ-028 With RST high at a clock edge, the following SHALL take effect on that edge:
  - pul_len = CENTER_US, target = CENTER_US;
  - state IDLE (so cmd_ready=1, busy=0);
  - prescaler = 0, microsecond counter = 0, frame_tick = 0.
REQ-029 RST SHALL take priority over command acceptance, over wrap, and over a ramp in progress (a ramp is aborted with no further steps).
REQ-030 After reset release, the first frame_tick SHALL occur exactly CLK_F*FRAME_US cycles after the first non-reset edge.

Verification
(The bench uses CLK_F=2 and FRAME_US=10, i.e. 20-cycle frames, unless noted.)
REQ-031 Reset: hold RST 3 cycles, then release -> pul_len=1500, cmd_ready=1, busy=0, and frame_tick pulses on cycle 20 and then every 20 cycles.
REQ-032 Up-ramp: accept angle 180 -> busy=1, cmd_ready=0.
  - first wrap: pul_len=1510; subsequent wraps add 10.
  - 100th wrap: pul_len=2500, and busy falls on that same edge.
REQ-033 Partial step and clamp: angle 1 from 1500 -> target 511; 98 steps down to 520, then the final step gives 511. Angle 200 -> treated as 180, target 2500.
REQ-034 No-op command: angle 90 from reset -> busy high for exactly 1 cycle (CONV), pul_len stays 1500, and no step occurs at the next wrap.
REQ-035 Back-pressure: hold cmd_valid with angle 0 during the ramp to 2500 -> not accepted while busy; accepted on the first IDLE cycle; pul_len then ramps down to 500.
REQ-036 Reset mid-ramp: assert RST after 5 steps (pul_len=1550) -> pul_len=1500 and busy=0 on the reset edge; the frame timer restarts, with the next frame_tick 20 cycles after release.

Source files
------------

// File: rtl/servo_ramp.sv
// servo_ramp
//   Converts an angle command (0..180 degrees) into a servo pulse width in
//   microseconds. The width slews toward the new target by at most STEP_US
//   per servo frame, so the servo never sees a sudden jump.
//
// Ports
//   CLK         in   1   clock, all logic on the rising edge
//   RST         in   1   synchronous active-high reset
//   cmd_valid   in   1   angle command present
//   cmd_ready   out  1   block can accept a command (state IDLE)
//   cmd_angle   in   8   target angle in degrees, values above 180 saturate
//   pul_len     out  16  registered pulse width in microseconds
//   busy        out  1   a command is being converted or ramped
//   frame_tick  out  1   registered one-cycle pulse at each frame boundary
module servo_ramp #(
    parameter int CLK_F     = 50,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 500,
    parameter int MAX_US    = 2500,
    parameter int CENTER_US = 1500,
    parameter int STEP_US   = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_angle,
    output logic [15:0] pul_len,
    output logic        busy,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic [15:0] us_q;
    logic [15:0] us_d;
    logic        frame_tick_q;
    logic [15:0] pul_len_q;
    logic [15:0] target_q;
    logic        cmd_ready_q;
    logic        busy_q;

    logic        presc_wrap_s;
    logic        wrap_s;
    logic [7:0]  angle_sat_s;
    logic [15:0] target_raw_s;
    logic [15:0] target_clamped_s;
    logic [15:0] diff_s;
    logic [15:0] toward_s;

    // Frame timer next state: prescaler divides CLK down to microseconds.
    always_comb begin
        presc_wrap_s = (presc_q == 16'(CLK_F - 1));
        wrap_s       = presc_wrap_s && (us_q == 16'(FRAME_US - 1));
        if (presc_wrap_s) begin
            presc_d = 16'd0;
            if (us_q == 16'(FRAME_US - 1)) begin
                us_d = 16'd0;
            end else begin
                us_d = us_q + 16'd1;
            end
        end else begin
            presc_d = presc_q + 16'd1;
            us_d    = us_q;
        end
    end

    // Angle to pulse width; 11*a + a/9 is floor(a*2000/180) without a divider.
    always_comb begin
        if (cmd_angle > 8'd180) begin
            angle_sat_s = 8'd180;
        end else begin
            angle_sat_s = cmd_angle;
        end
        target_raw_s = 16'(MIN_US) + (16'd11 * {8'd0, angle_sat_s})
                     + {8'd0, angle_sat_s / 8'd9};
        if (target_raw_s < 16'(MIN_US)) begin
            target_clamped_s = 16'(MIN_US);
        end else if (target_raw_s > 16'(MAX_US)) begin
            target_clamped_s = 16'(MAX_US);
        end else begin
            target_clamped_s = target_raw_s;
        end
    end

    // Distance to target and the value one full step closer to it.
    always_comb begin
        if (target_q >= pul_len_q) begin
            diff_s   = target_q - pul_len_q;
            toward_s = pul_len_q + 16'(STEP_US);
        end else begin
            diff_s   = pul_len_q - target_q;
            toward_s = pul_len_q - 16'(STEP_US);
        end
    end

    // Frame timer registers; free-running regardless of FSM state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q      <= 16'd0;
            us_q         <= 16'd0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            us_q         <= us_d;
            frame_tick_q <= wrap_s;
        end
    end

    // Command/ramp FSM with registered handshake and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            pul_len_q   <= 16'(CENTER_US);
            target_q    <= 16'(CENTER_US);
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        target_q    <= target_clamped_s;
                        state_q     <= S_CONV;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CONV: begin
                    // Target already reached: nothing to ramp.
                    if (target_q == pul_len_q) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (wrap_s) begin
                        // Final partial step lands exactly on target, no overshoot.
                        if (diff_s <= 16'(STEP_US)) begin
                            pul_len_q   <= target_q;
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            pul_len_q <= toward_s;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign pul_len    = pul_len_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with 20-cycle frames (CLK_F=2, FRAME_US=10).
module tb_servo_ramp;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_angle;
    logic [15:0] pul_len;
    logic        busy;
    logic        frame_tick;

    int vectors = 0;
    int errors  = 0;

    servo_ramp #(
        .CLK_F    (2),
        .FRAME_US (10)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_angle  (cmd_angle),
        .pul_len    (pul_len),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Advance to the next frame_tick, bounded to 25 cycles.
    task automatic wait_tick();
        int n;
        n = 0;
        step();
        while (frame_tick !== 1'b1 && n < 25) begin
            step();
            n++;
        end
        vectors++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: frame_tick=%b required 1 within 25 cycles", frame_tick);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_angle = 8'd0;
        repeat (3) step();
        RST = 1'b0;
        vectors++;
        if (pul_len !== 16'd1500) begin
            errors++; $display("FAIL reset_pul: got %0d want 1500", pul_len);
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b want 0", frame_tick);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i < 20; i++) begin
                step();
                vectors++;
                if (frame_tick !== 1'b0) begin
                    errors++; $display("FAIL tick_early: frame %0d cycle %0d got %b want 0", f, i, frame_tick);
                end
            end
            step();
            vectors++;
            if (frame_tick !== 1'b1) begin
                errors++; $display("FAIL tick_cycle20: frame %0d got %b want 1", f, frame_tick);
            end
        end
    endtask

    task automatic test_up_ramp();
        cmd_valid = 1'b1;
        cmd_angle = 8'd180;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL up_accept: busy=%b ready=%b want busy=1 ready=0", busy, cmd_ready);
        end
        for (int k = 1; k <= 100; k++) begin
            wait_tick();
            vectors++;
            if (pul_len !== 16'(1500 + 10 * k)) begin
                errors++; $display("FAIL up_step: wrap %0d got %0d want %0d", k, pul_len, 1500 + 10 * k);
            end
            vectors++;
            if (busy !== (k < 100)) begin
                errors++; $display("FAIL up_busy: wrap %0d got %b want %b", k, busy, (k < 100));
            end
            if (k == 1) begin
                repeat (5) step();
                vectors++;
                if (pul_len !== 16'd1510) begin
                    errors++; $display("FAIL up_hold: got %0d want 1510 between wraps", pul_len);
                end
            end
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL up_done_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_partial_clamp();
        do_reset();
        cmd_valid = 1'b1;
        cmd_angle = 8'd1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            wait_tick();
            vectors++;
            if (pul_len !== ((k < 99) ? 16'(1500 - 10 * k) : 16'd511)) begin
                errors++; $display("FAIL down_step: wrap %0d got %0d want %0d", k, pul_len,
                                   (k < 99) ? 1500 - 10 * k : 511);
            end
            if (k >= 98) begin
                vectors++;
                if (busy !== (k == 98)) begin
                    errors++; $display("FAIL down_busy: wrap %0d got %b want %b", k, busy, (k == 98));
                end
            end
        end
        cmd_valid = 1'b1;
        cmd_angle = 8'd200;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL sat_accept: busy got %b want 1", busy);
        end
        for (int k = 1; k <= 199; k++) begin
            wait_tick();
            vectors++;
            if (pul_len !== ((k < 199) ? 16'(511 + 10 * k) : 16'd2500)) begin
                errors++; $display("FAIL sat_step: wrap %0d got %0d want %0d", k, pul_len,
                                   (k < 199) ? 511 + 10 * k : 2500);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL sat_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_noop();
        do_reset();
        cmd_valid = 1'b1;
        cmd_angle = 8'd90;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL noop_conv: busy=%b ready=%b want 1/0", busy, cmd_ready);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL noop_idle: busy=%b ready=%b want 0/1", busy, cmd_ready);
        end
        wait_tick();
        vectors++;
        if (pul_len !== 16'd1500 || busy !== 1'b0) begin
            errors++; $display("FAIL noop_wrap: pul_len=%0d busy=%b want 1500/0", pul_len, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_valid = 1'b1;
        cmd_angle = 8'd180;
        step();
        cmd_angle = 8'd0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL bp_accept: busy got %b want 1", busy);
        end
        for (int k = 1; k <= 100; k++) begin
            wait_tick();
            vectors++;
            if (pul_len !== 16'(1500 + 10 * k)) begin
                errors++; $display("FAIL bp_up: wrap %0d got %0d want %0d", k, pul_len, 1500 + 10 * k);
            end
            if (k == 50) begin
                vectors++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL bp_hold: ready=%b busy=%b want 0/1", cmd_ready, busy);
                end
            end
        end
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle: ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_second: ready=%b busy=%b want 0/1", cmd_ready, busy);
        end
        for (int k = 1; k <= 200; k++) begin
            wait_tick();
            vectors++;
            if (pul_len !== 16'(2500 - 10 * k)) begin
                errors++; $display("FAIL bp_down: wrap %0d got %0d want %0d", k, pul_len, 2500 - 10 * k);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_done: busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        cmd_valid = 1'b1;
        cmd_angle = 8'd180;
        step();
        cmd_valid = 1'b0;
        repeat (5) wait_tick();
        repeat (3) step();
        vectors++;
        if (pul_len !== 16'd1550 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_before: pul_len=%0d busy=%b want 1550/1", pul_len, busy);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        vectors++;
        if (pul_len !== 16'd1500 || busy !== 1'b0 || cmd_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL mid_reset: pul_len=%0d busy=%b ready=%b tick=%b want 1500/0/1/0",
                               pul_len, busy, cmd_ready, frame_tick);
        end
        for (int i = 1; i < 20; i++) begin
            step();
            vectors++;
            if (frame_tick !== 1'b0) begin
                errors++; $display("FAIL mid_tick_early: cycle %0d got %b want 0", i, frame_tick);
            end
        end
        step();
        vectors++;
        if (frame_tick !== 1'b1 || pul_len !== 16'd1500 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_after: tick=%b pul_len=%0d busy=%b want 1/1500/0",
                               frame_tick, pul_len, busy);
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_partial_clamp();
        test_noop();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
